// File: rtl/xm_uart_rx.sv
// xm_uart_rx: 8-N-1 UART receiver, 16x oversampling, 3-sample majority vote per bit.
// baud_set encoding matches xm_uart_tx (0:9600 1:19200 2:38400 3:57600 4:115200, else 9600).
// Optional macro UART_RX_PARITY_EN: 8-E-1 frames with an extra PARITY state and parity_err output.
//
// state  | meaning
// IDLE   | waiting for a falling edge on the synchronized line
// START  | start bit; aborts back to IDLE if its majority vote reads high (glitch)
// DATA   | eight data bits, LSB first, shifted in at sample tick 9
// PARITY | received parity bit (UART_RX_PARITY_EN only)
// STOP   | stop bit; byte published at tick 9, then straight back to IDLE
`timescale 1ns/1ps

module xm_uart_rx #(
    parameter int CLK_FREQ = 20_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] baud_set,
    input  logic       rs232_rx,
    output logic [7:0] data_byte,
    output logic       rx_done,
    output logic       frame_err,
    output logic       uart_state
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    // Rounded oversample dividers: (f + 8*baud) / (16*baud)
    localparam logic [7:0] DIV_9600   = 8'((CLK_FREQ + 8 * 9600)   / (16 * 9600));
    localparam logic [7:0] DIV_19200  = 8'((CLK_FREQ + 8 * 19200)  / (16 * 19200));
    localparam logic [7:0] DIV_38400  = 8'((CLK_FREQ + 8 * 38400)  / (16 * 38400));
    localparam logic [7:0] DIV_57600  = 8'((CLK_FREQ + 8 * 57600)  / (16 * 57600));
    localparam logic [7:0] DIV_115200 = 8'((CLK_FREQ + 8 * 115200) / (16 * 115200));

    state_t      state_q, state_d;
    logic        sync1_q, sync2_q, prev_q;
    logic [2:0]  baud_q, baud_d;
    logic [7:0]  div_q, div_d;
    logic [3:0]  tick_q, tick_d;
    logic [2:0]  bit_q, bit_d;
    logic [1:0]  vote_q, vote_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic        ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic        par_q, par_d;
    logic        perr_q, perr_d;
`endif
    logic [7:0]  div_max;
    logic        tick_pulse;
    logic        maj;
    logic        fall;

    // Divider terminal count for the baud rate latched at the start edge
    always_comb begin
        unique case (baud_q)
            3'd1:    div_max = DIV_19200;
            3'd2:    div_max = DIV_38400;
            3'd3:    div_max = DIV_57600;
            3'd4:    div_max = DIV_115200;
            default: div_max = DIV_9600;
        endcase
    end

    assign tick_pulse = (div_q == div_max - 8'd1);
    assign fall       = prev_q & ~sync2_q;
    // vote_q[0] holds the tick-7 sample, vote_q[1] the tick-8 sample, sync2_q is tick 9
    assign maj        = (vote_q[0] & vote_q[1]) | (vote_q[0] & sync2_q) | (vote_q[1] & sync2_q);

    // Next-state and datapath logic for the receive FSM
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        div_d   = div_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        vote_d  = vote_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        if (state_q == S_IDLE) begin
            div_d  = 8'd0;
            tick_d = 4'd0;
            bit_d  = 3'd0;
            if (fall) begin
                state_d = S_START;
                baud_d  = baud_set;
            end
        end else begin
            div_d = tick_pulse ? 8'd0 : div_q + 8'd1;
            if (tick_pulse) begin
                tick_d = tick_q + 4'd1;
                if (tick_q == 4'd7) vote_d[0] = sync2_q;
                if (tick_q == 4'd8) vote_d[1] = sync2_q;
                unique case (state_q)
                    S_START: begin
                        if (tick_q == 4'd9 && maj) state_d = S_IDLE;
                        else if (tick_q == 4'd15) begin
                            state_d = S_DATA;
                            bit_d   = 3'd0;
                        end
                    end
                    S_DATA: begin
                        if (tick_q == 4'd9) shift_d = {maj, shift_q[7:1]};
                        if (tick_q == 4'd15) begin
                            if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state_d = S_PARITY;
`else
                                state_d = S_STOP;
`endif
                            end else begin
                                bit_d = bit_q + 3'd1;
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    S_PARITY: begin
                        if (tick_q == 4'd9) par_d = maj;
                        if (tick_q == 4'd15) state_d = S_STOP;
                    end
`endif
                    S_STOP: begin
                        // Leave mid-stop-bit so a back-to-back start edge is not missed
                        if (tick_q == 4'd9) begin
                            data_d  = shift_q;
                            done_d  = 1'b1;
                            ferr_d  = ~maj;
`ifdef UART_RX_PARITY_EN
                            perr_d  = par_q ^ (^shift_q);
`endif
                            state_d = S_IDLE;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    // State, synchronizer and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            baud_q  <= 3'd0;
            div_q   <= 8'd0;
            tick_q  <= 4'd0;
            bit_q   <= 3'd0;
            vote_q  <= 2'd0;
            shift_q <= 8'd0;
            data_q  <= 8'd0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sync1_q <= rs232_rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            baud_q  <= baud_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            vote_q  <= vote_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign data_byte  = data_q;
    assign rx_done    = done_q;
    assign frame_err  = ferr_q;
    assign uart_state = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_xm_uart_rx.sv
// Directed testbench for xm_uart_rx at 20 MHz; honours UART_RX_PARITY_EN when defined.
`timescale 1ns/1ps

module tb_xm_uart_rx;

    localparam real BIT115  = 8680.0;
    localparam real BIT9600 = 104166.67;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] baud_set = 3'd4;
    logic       rs232_rx = 1'b1;
    logic [7:0] data_byte;
    logic       rx_done;
    logic       frame_err;
    logic       uart_state;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    logic       bad_par = 1'b0;
    logic       got_p[$];
`endif

    int         checks = 0;
    int         errors = 0;
    int         orphan_fe = 0;
    logic [7:0] got_b[$];
    logic       got_f[$];

    xm_uart_rx #(.CLK_FREQ(20_000_000)) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_set   (baud_set),
        .rs232_rx   (rs232_rx),
        .data_byte  (data_byte),
        .rx_done    (rx_done),
        .frame_err  (frame_err),
        .uart_state (uart_state)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #25 clk = ~clk;

    // Record every strobe cycle; a frame_err without rx_done is tallied separately
    always @(negedge clk) begin
        if (rx_done) begin
            got_b.push_back(data_byte);
            got_f.push_back(frame_err);
`ifdef UART_RX_PARITY_EN
            got_p.push_back(parity_err);
`endif
        end else if (frame_err) begin
            orphan_fe++;
        end
    end

    function automatic logic [7:0] get_b(input int i);
        if (i < got_b.size()) return got_b[i];
        return 8'hxx;
    endfunction

    function automatic logic get_f(input int i);
        if (i < got_f.size()) return got_f[i];
        return 1'bx;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input real bit_ns, input logic stop_val);
        rs232_rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rs232_rx = b[i];
            #(bit_ns);
        end
`ifdef UART_RX_PARITY_EN
        rs232_rx = (^b) ^ bad_par;
        #(bit_ns);
`endif
        rs232_rx = stop_val;
        #(bit_ns);
    endtask

    initial begin
        #1000;
        @(negedge clk);
        chk("reset_data_byte", 32'(data_byte), 32'h00);
        chk("reset_rx_done", 32'(rx_done), 32'h0);
        chk("reset_frame_err", 32'(frame_err), 32'h0);
        chk("reset_uart_state", 32'(uart_state), 32'h0);
        rst = 1'b1;
        #1000;

        // Clean 0xA5 at 115200
        send_byte(8'hA5, BIT115, 1'b1);
        rs232_rx = 1'b1;
        #(BIT115);
        @(negedge clk);
        chk("a5_count", 32'(got_b.size()), 32'd1);
        chk("a5_byte", 32'(get_b(0)), 32'hA5);
        chk("a5_ferr", 32'(get_f(0)), 32'h0);
        chk("a5_data_byte", 32'(data_byte), 32'hA5);
        chk("a5_idle", 32'(uart_state), 32'h0);

        // 2 us low glitch
        rs232_rx = 1'b0;
        #500;
        @(negedge clk);
        chk("glitch_started", 32'(uart_state), 32'h1);
        #1475;
        rs232_rx = 1'b1;
        #(BIT115 - 2000.0);
        @(negedge clk);
        chk("glitch_aborted", 32'(uart_state), 32'h0);
        chk("glitch_no_strobe", 32'(got_b.size()), 32'd1);

        // Stop bit held low
        send_byte(8'h3C, BIT115, 1'b0);
        rs232_rx = 1'b1;
        #(BIT115);
        @(negedge clk);
        chk("ferr_count", 32'(got_b.size()), 32'd2);
        chk("ferr_byte", 32'(get_b(1)), 32'h3C);
        chk("ferr_flag", 32'(get_f(1)), 32'h1);
        chk("ferr_only_with_done", 32'(orphan_fe), 32'd0);

        // Back-to-back at 9600
        baud_set = 3'd0;
        #1000;
        send_byte(8'h00, BIT9600, 1'b1);
        send_byte(8'hFF, BIT9600, 1'b1);
        send_byte(8'h55, BIT9600, 1'b1);
        rs232_rx = 1'b1;
        #5000;
        @(negedge clk);
        chk("b2b_count", 32'(got_b.size()), 32'd5);
        chk("b2b_byte0", 32'(get_b(2)), 32'h00);
        chk("b2b_byte1", 32'(get_b(3)), 32'hFF);
        chk("b2b_byte2", 32'(get_b(4)), 32'h55);
        chk("b2b_ferr2", 32'(get_f(4)), 32'h0);

        // 0x81 with TX +2% slow, then -2% fast while baud_set toggles mid-frame
        baud_set = 3'd4;
        #1000;
        send_byte(8'h81, BIT115 * 1.02, 1'b1);
        rs232_rx = 1'b1;
        #(BIT115);
        fork
            send_byte(8'h81, BIT115 * 0.98, 1'b1);
            begin
                #(3.0 * BIT115);
                baud_set = 3'd0;
                #(3.0 * BIT115);
                baud_set = 3'd2;
            end
        join
        baud_set = 3'd4;
        rs232_rx = 1'b1;
        #(BIT115);
        @(negedge clk);
        chk("skew_count", 32'(got_b.size()), 32'd7);
        chk("skew_slow_byte", 32'(get_b(5)), 32'h81);
        chk("skew_fast_byte", 32'(get_b(6)), 32'h81);
        chk("skew_fast_ferr", 32'(get_f(6)), 32'h0);

        // Reset pulse during data bit 4 of 0xF0
        fork
            send_byte(8'hF0, BIT115, 1'b1);
            begin
                #(5.3 * BIT115);
                rst = 1'b0;
                #200;
                @(negedge clk);
                chk("midrst_data_byte", 32'(data_byte), 32'h00);
                chk("midrst_uart_state", 32'(uart_state), 32'h0);
                chk("midrst_rx_done", 32'(rx_done), 32'h0);
                rst = 1'b1;
            end
        join
        rs232_rx = 1'b1;
        #(BIT115);
        @(negedge clk);
        chk("midrst_no_strobe", 32'(got_b.size()), 32'd7);
        chk("midrst_no_update", 32'(data_byte), 32'h00);
        send_byte(8'h42, BIT115, 1'b1);
        rs232_rx = 1'b1;
        #(BIT115);
        @(negedge clk);
        chk("post_rst_count", 32'(got_b.size()), 32'd8);
        chk("post_rst_byte", 32'(get_b(7)), 32'h42);

`ifdef UART_RX_PARITY_EN
        chk("par_good_42", 32'(got_p[7]), 32'h0);
        bad_par = 1'b1;
        send_byte(8'h07, BIT115, 1'b1);
        bad_par = 1'b0;
        rs232_rx = 1'b1;
        #(BIT115);
        @(negedge clk);
        chk("par_count", 32'(got_b.size()), 32'd9);
        chk("par_byte", 32'(get_b(8)), 32'h07);
        chk("par_err", 32'((got_p.size() > 8) ? got_p[8] : 1'bx), 32'h1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
